// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control FSM for the MIPS-lite core.
//
// Sequences each instruction through IF/ID/EX/MEM/WB and drives the datapath
// strobes and mux selects. Exactly one PC write is issued per instruction, in
// the final state of its path, after which the FSM returns to IF.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_op         IR[31:26]
//   i_funct      IR[5:0]
//   i_zero       ALU equality flag (rs == rt), used by beq in EX
//   o_state      current state: IF=0, ID=1, EX=2, MEM=3, WB=4
//   o_irWrite    IR load strobe
//   o_pcWrite    PC load strobe
//   o_npcSel     next-PC source: 0 PC+4, 1 branch, 2 jump index, 3 GPR[rs]
//   o_regWrite   register file write enable
//   o_regDst     write register: 0 rt, 1 rd, 2 $31
//   o_wdSel      write data: 0 ALU, 1 memory, 2 PC+4
//   o_aluBSel    ALU B: 0 GPR[rt], 1 zext(imm), 2 sext(imm)
//   o_aluOp      ALU op: 0 add, 1 sub, 2 or, 3 lui
//   o_memWrite   data memory write enable
//   o_instCount  retired instruction count (PC writes since reset)
// -----------------------------------------------------------------------------
module mc_ctrl (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [5:0]  i_op,
   input  logic [5:0]  i_funct,
   input  logic        i_zero,
   output logic [2:0]  o_state,
   output logic        o_irWrite,
   output logic        o_pcWrite,
   output logic [1:0]  o_npcSel,
   output logic        o_regWrite,
   output logic [1:0]  o_regDst,
   output logic [1:0]  o_wdSel,
   output logic [1:0]  o_aluBSel,
   output logic [1:0]  o_aluOp,
   output logic        o_memWrite,
   output logic [31:0] o_instCount
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW,
      C_BEQ, C_LUI, C_J, C_JAL, C_ILL
   } class_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   class_e      cls;

   // Instruction class decode from the IR fields.
   always_comb begin
      cls = C_ILL;
      case (i_op)
         6'b000000: begin
            case (i_funct)
               6'b100001: cls = C_ADDU;
               6'b100011: cls = C_SUBU;
               6'b001000: cls = C_JR;
               default:   cls = C_ILL;
            endcase
         end
         6'b001101: cls = C_ORI;
         6'b100011: cls = C_LW;
         6'b101011: cls = C_SW;
         6'b000100: cls = C_BEQ;
         6'b001111: cls = C_LUI;
         6'b000010: cls = C_J;
         6'b000011: cls = C_JAL;
         default:   cls = C_ILL;
      endcase
   end

   // State register and retired-instruction counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_IF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            case (cls)
               C_J, C_JR, C_ILL: state_d = S_IF;
               C_JAL:            state_d = S_WB;
               default:          state_d = S_EX;
            endcase
         end
         S_EX: begin
            case (cls)
               C_BEQ:      state_d = S_IF;
               C_LW, C_SW: state_d = S_MEM;
               default:    state_d = S_WB;
            endcase
         end
         S_MEM:   state_d = (cls == C_LW) ? S_WB : S_IF;
         S_WB:    state_d = S_IF;
         default: state_d = S_IF;
      endcase
   end

   // Output decode. Everything is held at zero while reset is asserted so an
   // aborted instruction cannot write anything in the reset cycle.
   always_comb begin
      o_irWrite  = 1'b0;
      o_pcWrite  = 1'b0;
      o_npcSel   = 2'd0;
      o_regWrite = 1'b0;
      o_regDst   = 2'd0;
      o_wdSel    = 2'd0;
      o_aluBSel  = 2'd0;
      o_aluOp    = 2'd0;
      o_memWrite = 1'b0;
      if (!i_reset) begin
         // ALU selects are a pure function of class, so they stay stable
         // from EX through MEM and WB without extra registers.
         if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
            case (cls)
               C_SUBU:     o_aluOp = 2'd1;
               C_BEQ:      o_aluOp = 2'd1;
               C_ORI:      begin o_aluBSel = 2'd1; o_aluOp = 2'd2; end
               C_LUI:      begin o_aluBSel = 2'd1; o_aluOp = 2'd3; end
               C_LW, C_SW: o_aluBSel = 2'd2;
               default:    ;
            endcase
         end
         case (state_q)
            S_IF: o_irWrite = 1'b1;
            S_ID: begin
               case (cls)
                  C_J:     begin o_pcWrite = 1'b1; o_npcSel = 2'd2; end
                  C_JR:    begin o_pcWrite = 1'b1; o_npcSel = 2'd3; end
                  C_ILL:   o_pcWrite = 1'b1;
                  default: ;
               endcase
            end
            S_EX: begin
               if (cls == C_BEQ) begin
                  o_pcWrite = 1'b1;
                  o_npcSel  = i_zero ? 2'd1 : 2'd0;
               end
            end
            S_MEM: begin
               if (cls == C_SW) begin
                  o_memWrite = 1'b1;
                  o_pcWrite  = 1'b1;
               end
            end
            S_WB: begin
               o_regWrite = 1'b1;
               o_pcWrite  = 1'b1;
               case (cls)
                  C_ADDU, C_SUBU: o_regDst = 2'd1;
                  C_LW:           o_wdSel  = 2'd1;
                  C_JAL: begin
                     o_regDst = 2'd2;
                     o_wdSel  = 2'd2;
                     o_npcSel = 2'd2;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_comb cnt_d = o_pcWrite ? cnt_q + 32'd1 : cnt_q;

   assign o_state     = state_q;
   assign o_instCount = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

   logic        clk;
   logic        rst;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic        zero;
   logic [2:0]  st;
   logic        irw, pcw, rw, mw;
   logic [1:0]  npc, rdst, wd, bsel, aop;
   logic [31:0] cnt;

   mc_ctrl dut (
      .i_clk(clk), .i_reset(rst), .i_op(op), .i_funct(funct), .i_zero(zero),
      .o_state(st), .o_irWrite(irw), .o_pcWrite(pcw), .o_npcSel(npc),
      .o_regWrite(rw), .o_regDst(rdst), .o_wdSel(wd), .o_aluBSel(bsel),
      .o_aluOp(aop), .o_memWrite(mw), .o_instCount(cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int unsigned mcount = 0;

   // Instruction classes used by the reference model.
   localparam int ADDU = 0, SUBU = 1, JR = 2, ORI = 3, LW = 4, SW = 5,
                  BEQ = 6, LUI = 7, J = 8, JAL = 9, ILL = 10;

   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      int         exp_cpi;
      int         exp_npc;   // npcSel expected on the PC-write cycle
      int         abort_k;   // cycle index at which reset is asserted, -1 none
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00) return (f == 6'h21) ? ADDU : (f == 6'h23) ? SUBU : (f == 6'h08) ? JR : ILL;
      case (o)
         6'h0D: return ORI;
         6'h23: return LW;
         6'h2B: return SW;
         6'h04: return BEQ;
         6'h0F: return LUI;
         6'h02: return J;
         6'h03: return JAL;
         default: return ILL;
      endcase
   endfunction

   // Path of states per class, written out as the listed state sequences.
   function automatic int path_at(input int c, input int k);
      int p [5];
      case (c)
         ADDU, SUBU, ORI, LUI: p = '{0, 1, 2, 4, -1};
         LW:                   p = '{0, 1, 2, 3, 4};
         SW:                   p = '{0, 1, 2, 3, -1};
         BEQ:                  p = '{0, 1, 2, -1, -1};
         JAL:                  p = '{0, 1, 4, -1, -1};
         default:              p = '{0, 1, -1, -1, -1};
      endcase
      return (k < 5) ? p[k] : -1;
   endfunction

   function automatic int cpi_of(input int c);
      int n = 0;
      for (int k = 0; k < 5; k++) if (path_at(c, k) >= 0) n++;
      return n;
   endfunction

   // Expected output vector for step k of an instruction of class c.
   // Packing: {state, irw, pcw, npc, rw, rdst, wd, bsel, aop, mw}.
   function automatic logic [16:0] model(input int c, input logic z, input int k);
      int s;
      bit last;
      logic [1:0] e_npc, e_rdst, e_wd, e_bsel, e_aop;
      s = path_at(c, k);
      last = (k == cpi_of(c) - 1);
      e_npc = 2'd0; e_rdst = 2'd0; e_wd = 2'd0; e_bsel = 2'd0; e_aop = 2'd0;
      if (last) begin
         if (c == J || c == JAL) e_npc = 2'd2;
         else if (c == JR) e_npc = 2'd3;
         else if (c == BEQ) e_npc = z ? 2'd1 : 2'd0;
      end
      if (s >= 2) begin
         case (c)
            SUBU, BEQ: e_aop = 2'd1;
            ORI:       begin e_bsel = 2'd1; e_aop = 2'd2; end
            LUI:       begin e_bsel = 2'd1; e_aop = 2'd3; end
            LW, SW:    e_bsel = 2'd2;
            default:   ;
         endcase
      end
      if (s == 4) begin
         e_rdst = (c == ADDU || c == SUBU) ? 2'd1 : (c == JAL) ? 2'd2 : 2'd0;
         e_wd   = (c == LW) ? 2'd1 : (c == JAL) ? 2'd2 : 2'd0;
      end
      return {3'(s), (k == 0), last, e_npc, (s == 4), e_rdst, e_wd, e_bsel, e_aop,
              (s == 3 && c == SW)};
   endfunction

   function automatic logic [16:0] dut_vec();
      return {st, irw, pcw, npc, rw, rdst, wd, bsel, aop, mw};
   endfunction

   // Runs one instruction starting in IF; DUT is sampled 1-2 time units after
   // each rising edge. The loop follows the DUT but is bounded to 8 cycles.
   task automatic run(input vec_t v);
      int c, n, k;
      c = cls_of(v.op, v.funct);
      n = cpi_of(c);
      op = v.op; funct = v.funct; zero = v.zero;
      k = 0;
      do begin
         #1;
         if (k == v.abort_k) begin
            rst = 1'b1;
            #1;
            check("reset_strobes", 64'(dut_vec()), 64'({3'(path_at(c, k)), 14'd0}));
            @(posedge clk); #1;
            check("reset_state", 64'(st), 64'd0);
            check("reset_count", 64'(cnt), 64'd0);
            mcount = 0;
            rst = 1'b0;
            return;
         end
         if (k < n) check("cycle_outputs", 64'(dut_vec()), 64'(model(c, v.zero, k)));
         check("inst_count", 64'(cnt), 64'(mcount));
         if (k == v.exp_cpi - 1 && v.exp_npc >= 0) check("npc_on_pcwrite", 64'({pcw, npc}), 64'({1'b1, 2'(v.exp_npc)}));
         if (k == n - 1) mcount++;
         @(posedge clk); #1;
         k++;
      end while (st != 3'd0 && k < 8);
      check("cpi", 64'(k), 64'(v.exp_cpi));
   endtask

   vec_t tab [14];
   logic [11:0] legal [10];

   initial begin
      tab[0]  = '{6'h00, 6'h21, 1'b0, 4, 0, -1};   // addu
      tab[1]  = '{6'h23, 6'h00, 1'b0, 5, 0, -1};   // lw
      tab[2]  = '{6'h2B, 6'h11, 1'b1, 4, 0, -1};   // sw
      tab[3]  = '{6'h04, 6'h00, 1'b1, 3, 1, -1};   // beq taken
      tab[4]  = '{6'h04, 6'h00, 1'b0, 3, 0, -1};   // beq not taken
      tab[5]  = '{6'h03, 6'h00, 1'b0, 3, 2, -1};   // jal
      tab[6]  = '{6'h00, 6'h08, 1'b0, 2, 3, -1};   // jr
      tab[7]  = '{6'h3F, 6'h00, 1'b0, 2, 0, -1};   // illegal op
      tab[8]  = '{6'h00, 6'h23, 1'b1, 4, 0, -1};   // subu
      tab[9]  = '{6'h0D, 6'h00, 1'b0, 4, 0, -1};   // ori
      tab[10] = '{6'h0F, 6'h00, 1'b0, 4, 0, -1};   // lui
      tab[11] = '{6'h02, 6'h00, 1'b0, 2, 2, -1};   // j
      tab[12] = '{6'h23, 6'h00, 1'b0, 5, -1, 3};   // lw, reset in MEM
      tab[13] = '{6'h00, 6'h21, 1'b0, 4, -1, 3};   // addu, reset in WB

      legal = '{{6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h08}, {6'h0D, 6'h00},
                {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h0F, 6'h00},
                {6'h02, 6'h00}, {6'h03, 6'h00}};

      rst = 1'b1; op = '0; funct = '0; zero = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_state", 64'(st), 64'd0);
         check("rst_count", 64'(cnt), 64'd0);
         check("rst_outputs", 64'(dut_vec()), 64'd0);
      end
      rst = 1'b0;

      foreach (tab[i]) run(tab[i]);

      for (int i = 0; i < 400; i++) begin
         vec_t v;
         int c, sel;
         sel = int'($urandom_range(0, 13));
         if (sel < 10) begin
            v.op = legal[sel][11:6];
            v.funct = (legal[sel][11:6] == 6'h00) ? legal[sel][5:0] : 6'($urandom);
         end else begin
            v.op = 6'($urandom);
            v.funct = 6'($urandom);
         end
         v.zero = 1'($urandom);
         c = cls_of(v.op, v.funct);
         v.exp_cpi = cpi_of(c);
         v.exp_npc = -1;
         v.abort_k = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, v.exp_cpi - 1)) : -1;
         run(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS-lite core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It issues the write strobes and mux selects for the PC register, IR, register file and data memory, including the single PC write per instruction and its next-PC source. It sits between the instruction decode fields of the IR and the datapath, and replaces the per-cycle PC update of the single-cycle core.

## Interface
Parameters:
- none. Opcode/funct encodings are fixed to the MIPS-lite subset listed under Operation.

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_op  in  6  IR[31:26]; valid from ID onward.
- i_funct  in  6  IR[5:0]; valid from ID onward.
- i_zero  in  1  ALU equality flag, rs == rt; valid in EX.
- o_state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
- o_irWrite  out  1  latch instruction memory output into IR.
- o_pcWrite  out  1  PC register loads the next-PC value at this edge.
- o_npcSel  out  2  next-PC source: 0 = PC+4, 1 = PC+4+(sext(imm)<<2), 2 = {PC[31:28], idx, 2'b00}, 3 = GPR[rs].
- o_regWrite  out  1  GRF write enable.
- o_regDst  out  2  write-register select: 0 = rt, 1 = rd, 2 = $31.
- o_wdSel  out  2  GRF write-data select: 0 = ALU, 1 = memory, 2 = PC+4.
- o_aluBSel  out  2  ALU B source: 0 = GPR[rt], 1 = zext(imm), 2 = sext(imm).
- o_aluOp  out  2  ALU op: 0 = add, 1 = sub, 2 = or, 3 = lui (B<<16).
- o_memWrite  out  1  DM write enable.
- o_instCount  out  32  count of retired instructions, i.e. PC writes since reset.

## Operation
- Decode classes:
  - addu: op 000000, funct 100001.
  - subu: op 000000, funct 100011.
  - jr: op 000000, funct 001000.
  - ori: 001101.
  - lw: 100011.
  - sw: 101011.
  - beq: 000100.
  - lui: 001111.
  - j: 000010.
  - jal: 000011.
  - Anything else is "illegal".
- State paths; the PC-write state is marked *:
  - addu/subu: IF→ID→EX→WB*.
  - ori/lui: IF→ID→EX→WB*.
  - lw: IF→ID→EX→MEM→WB*.
  - sw: IF→ID→EX→MEM*.
  - beq: IF→ID→EX*.
  - jal: IF→ID→WB*.
  - j: IF→ID*.
  - jr: IF→ID*.
  - illegal: IF→ID*.
- From every * state the next state is IF.
- IF: o_irWrite=1; all other strobes 0.
- ID: strobes 0 except for j, jr and illegal, which assert o_pcWrite with npcSel = 2, 3 and 0 respectively.
- EX: o_aluBSel and o_aluOp set per class:
  - addu: 0/0.
  - subu: 0/1.
  - ori: 1/2.
  - lui: 1/3.
  - lw and sw: 2/0.
  - beq: 0/1, with o_pcWrite=1 and o_npcSel = i_zero ? 1 : 0.
- EX selects are held stable through MEM and WB.
- MEM: sw asserts o_memWrite and o_pcWrite with npcSel=0. lw asserts no strobes.
- WB: o_regWrite=1 and o_pcWrite=1.
  - addu/subu: regDst=1, wdSel=0, npcSel=0.
  - ori/lui: regDst=0, wdSel=0, npcSel=0.
  - lw: regDst=0, wdSel=1, npcSel=0.
  - jal: regDst=2, wdSel=2, npcSel=2.
- Default for every unlisted output in every state: 0.
- o_instCount increments by 1 on each edge where o_pcWrite=1. It wraps 0xFFFFFFFF→0 with no flag.
- Exactly one o_pcWrite pulse per instruction. PC and IR never written in the same cycle.

## Timing
- Outputs are Moore-decoded from the state register plus i_op/i_funct. The beq npcSel additionally depends on i_zero. No registered-output latency.
- Reset: on an edge with i_reset=1:
  - state←IF, o_instCount←0.
  - While i_reset=1, all write strobes (irWrite, pcWrite, regWrite, memWrite) are forced to 0. Selects are 0.
- After reset release, the first cycle is IF with o_irWrite=1.
- Reset mid-instruction, in any state, aborts the instruction: no partial writes after the reset cycle, next state IF.
- CPI per instruction:
  - j, jr, illegal: 2.
  - beq, jal: 3.
  - sw, addu, subu, ori, lui: 4.
  - lw: 5.
- Unused state encodings 5–7 go to IF on the next edge with all strobes 0 and no count increment.

## Test plan
- Reset then addu, with PC at 0x00003000: states 0,1,2,4. o_regWrite=1, o_regDst=1, o_pcWrite=1 in cycle 4 only. o_instCount=1.
- lw: 5 cycles. WB has wdSel=1 and regDst=0. MEM has no strobe. Then sw: MEM has o_memWrite=1 and o_pcWrite=1, 4 cycles total.
- beq: with i_zero=1 in EX, npcSel=1; with i_zero=0, npcSel=0. pcWrite in EX (cycle 3), next state IF.
- jal: IF, ID, WB. WB has regDst=2, wdSel=2, npcSel=2, regWrite=1. Then jr: ID asserts pcWrite with npcSel=3, 2 cycles.
- Illegal op 111111: 2 cycles, npcSel=0, no regWrite or memWrite, count +1. Reset asserted in lw MEM: no WB write, state=IF, count=0.
